// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// fft_frame_ctrl : config/frame sequencer between a sample source and an FFT core
// Rev 1.0
// ============================================================================
module fft_frame_ctrl #(
  parameter int NFFT_LOG2 = 10,
  parameter int DATA_W    = 32,
  parameter int CFG_W     = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [7:0]        nframes,
  input  logic              fwd_inv,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              cfg_tvalid,
  output logic [CFG_W-1:0]  cfg_tdata,
  input  logic              cfg_tready,
  output logic              s_axis_tvalid,
  output logic [DATA_W-1:0] s_axis_tdata,
  output logic              s_axis_tlast,
  input  logic              s_axis_tready,
  input  logic              m_axis_tvalid,
  input  logic              m_axis_tlast,
  output logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_idx,
  output logic              err_tlast
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CFG      = 3'd1,
    S_LOAD     = 3'd2,
    S_WAIT_OUT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [NFFT_LOG2-1:0] CNT_MAX = '1;

  state_t               state;
  logic [NFFT_LOG2-1:0] in_cnt;
  logic [NFFT_LOG2-1:0] out_cnt;
  logic [7:0]           nframes_q;

  logic       in_load;
  logic       in_fire;
  logic       in_last;
  logic       out_fire;
  logic       out_last;
  logic       frame_end;
  logic       frame_err;
  logic [7:0] last_idx;

  // Input path is a pure pass-through gated by the LOAD state
  assign in_load       = (state == S_LOAD);
  assign s_axis_tvalid = in_load & src_valid;
  assign src_ready     = in_load & s_axis_tready;
  assign s_axis_tdata  = in_load ? src_data : '0;
  assign in_last       = (in_cnt == CNT_MAX);
  assign s_axis_tlast  = in_load & in_last;
  assign in_fire       = s_axis_tvalid & s_axis_tready;

  assign m_axis_tready = in_load | (state == S_WAIT_OUT);
  assign out_fire      = m_axis_tvalid & m_axis_tready;
  assign out_last      = (out_cnt == CNT_MAX);
  // A result frame closes on tlast or on the Nth beat, whichever comes first
  assign frame_end     = out_fire & (m_axis_tlast | out_last);
  assign frame_err     = out_fire & (m_axis_tlast ^ out_last);

  assign last_idx = (nframes_q == 8'd0) ? 8'd0 : nframes_q - 8'd1;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      nframes_q  <= '0;
      cfg_tvalid <= 1'b0;
      cfg_tdata  <= '0;
      frame_idx  <= '0;
      err_tlast  <= 1'b0;
    end else begin
      err_tlast <= frame_err;
      if (out_fire) begin
        out_cnt <= frame_end ? '0 : out_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            nframes_q  <= nframes;
            cfg_tdata  <= {{(CFG_W-1){1'b0}}, fwd_inv};
            cfg_tvalid <= 1'b1;
            frame_idx  <= '0;
            in_cnt     <= '0;
            state      <= S_CFG;
          end
        end
        S_CFG: begin
          if (cfg_tready) begin
            cfg_tvalid <= 1'b0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_fire) begin
            if (in_last) begin
              in_cnt <= '0;
              state  <= S_WAIT_OUT;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        S_WAIT_OUT: begin
          if (frame_end) begin
            if (frame_idx == last_idx) begin
              state <= S_DONE;
            end else begin
              frame_idx <= frame_idx + 8'd1;
              state     <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fft_frame_ctrl : scoreboard bench for fft_frame_ctrl with N=16
// Rev 1.0
// ============================================================================
module tb_fft_frame_ctrl;

  localparam int NL = 4;
  localparam int N  = 16;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          sys_rst_n;
  logic          start;
  logic [7:0]    nframes;
  logic          fwd_inv;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          cfg_tvalid;
  logic [CW-1:0] cfg_tdata;
  logic          cfg_tready;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          busy;
  logic          done;
  logic [7:0]    frame_idx;
  logic          err_tlast;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.NFFT_LOG2(NL), .DATA_W(DW), .CFG_W(CW)) dut (
    .sys_clk(clk), .sys_rst_n(sys_rst_n), .start(start), .nframes(nframes),
    .fwd_inv(fwd_inv), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .cfg_tvalid(cfg_tvalid), .cfg_tdata(cfg_tdata),
    .cfg_tready(cfg_tready), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .busy(busy), .done(done), .frame_idx(frame_idx), .err_tlast(err_tlast)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [7:0]    idx;
  } beat_t;

  beat_t      exp_in[$];
  logic [7:0] exp_cfg[$];
  logic [7:0] exp_done[$];
  logic [7:0] exp_err[$];

  int n_cmp = 0;
  int n_fail = 0;
  int test_no = 0;
  int src_k = 0;
  int src_total = 0;
  bit src_en = 0;
  bit src_stall = 0;
  int res_pending = 0;
  int rf = 0;
  int inj_early = -1;
  int inj_miss = -1;
  int in_beats = 0;
  int done_cnt = 0;
  int hold_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int k);
    return {8'hA5, 8'(test_no), 16'(k)};
  endfunction

  task automatic finish_now();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  // Sample source and FFT input-side backpressure
  initial begin
    bit acc;
    src_valid = 0; src_data = '0; s_axis_tready = 1;
    forever begin
      @(negedge clk);
      acc = src_valid && src_ready;
      @(posedge clk); #1;
      if (acc) src_k++;
      src_valid = src_en && (src_k < src_total) && (!src_stall || ($urandom_range(0, 2) != 0));
      src_data = mk(src_k);
      s_axis_tready = !src_stall || ($urandom_range(0, 2) != 0);
    end
  end

  // FFT result stream: one result frame per completed input frame
  initial begin
    m_axis_tvalid = 0; m_axis_tlast = 0;
    forever begin
      @(posedge clk); #1;
      if (res_pending > 0) begin
        int len;
        len = (rf == inj_early) ? 10 : N;
        for (int b = 0; b < len; b++) begin
          bit acc;
          do begin
            m_axis_tvalid = !src_stall || ($urandom_range(0, 3) != 0);
            m_axis_tlast  = (b == len - 1) && (rf != inj_miss);
            @(negedge clk);
            acc = m_axis_tvalid && m_axis_tready;
            @(posedge clk); #1;
          end while (!acc);
        end
        m_axis_tvalid = 0; m_axis_tlast = 0;
        res_pending--;
        rf++;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents something
  always @(negedge clk) begin
    if (sys_rst_n) begin
      if (cfg_tvalid) begin
        if (exp_cfg.size() == 0) chk("cfg_unexpected", 64'(cfg_tvalid), 64'd0);
        else if (cfg_tready) chk("cfg_tdata", 64'(cfg_tdata), 64'(exp_cfg.pop_front()));
        else begin
          hold_cnt++;
          chk("cfg_hold_tdata", 64'(cfg_tdata), 64'(exp_cfg[0]));
          chk("cfg_hold_src_ready", 64'(src_ready), 64'd0);
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        if (exp_in.size() == 0) chk("beat_unexpected", 64'(s_axis_tvalid), 64'd0);
        else begin
          beat_t b;
          b = exp_in.pop_front();
          chk("s_axis_beat", 64'({s_axis_tdata, s_axis_tlast, frame_idx}),
              64'({b.data, b.last, b.idx}));
        end
        in_beats++;
        if (s_axis_tlast) res_pending++;
      end
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
        else chk("done_frame_idx", 64'({busy, frame_idx}), 64'({1'b1, exp_done.pop_front()}));
        done_cnt++;
      end
      if (err_tlast) begin
        if (exp_err.size() == 0) chk("err_unexpected", 64'(err_tlast), 64'd0);
        else chk("err_tlast_frame_idx", 64'(frame_idx), 64'(exp_err.pop_front()));
      end
    end
  end

  task automatic check_zero(input string name);
    chk(name, 64'({cfg_tvalid, cfg_tdata, s_axis_tvalid, s_axis_tdata, s_axis_tlast,
                   src_ready, m_axis_tready, busy, done, frame_idx, err_tlast}), 64'd0);
  endtask

  task automatic launch(input logic [7:0] nf, input bit fwd, input bit stall);
    int eff;
    test_no++;
    eff = (nf == 0) ? 1 : int'(nf);
    exp_cfg.push_back({7'd0, fwd});
    for (int k = 0; k < eff * N; k++)
      exp_in.push_back('{data: mk(k), last: (k % N == N - 1), idx: 8'(k / N)});
    exp_done.push_back(8'(eff - 1));
    if (inj_early >= 0 && inj_early < eff)
      exp_err.push_back(8'((inj_early == eff - 1) ? inj_early : inj_early + 1));
    if (inj_miss >= 0 && inj_miss < eff)
      exp_err.push_back(8'((inj_miss == eff - 1) ? inj_miss : inj_miss + 1));
    src_k = 0; src_total = eff * N; rf = 0; in_beats = 0;
    src_stall = stall; src_en = 1;
    @(posedge clk); #1;
    start = 1; nframes = nf; fwd_inv = fwd;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic finish_test(input string name);
    int c;
    int base;
    c = 0;
    base = done_cnt;
    while (done_cnt == base && c < 3000) begin
      @(posedge clk);
      c++;
    end
    if (done_cnt == base) begin
      chk({name, "_timeout_done"}, 64'(done_cnt), 64'(base + 1));
      finish_now();
    end
    repeat (4) @(negedge clk);
    chk({name, "_in_drained"}, 64'(exp_in.size()), 64'd0);
    chk({name, "_queues_drained"}, 64'(exp_cfg.size() + exp_done.size() + exp_err.size()), 64'd0);
    chk({name, "_idle"}, 64'({busy, done, err_tlast}), 64'd0);
    src_en = 0; src_stall = 0; inj_early = -1; inj_miss = -1;
  endtask

  initial begin
    int c;
    sys_rst_n = 0; start = 0; nframes = 0; fwd_inv = 0; cfg_tready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_outputs_in_reset");
    @(posedge clk); #1;
    sys_rst_n = 1;
    @(negedge clk);
    check_zero("reset_outputs_after");

    // single forward frame, no stalls
    launch(8'd1, 1'b1, 1'b0);
    finish_test("t1_single");

    // three inverse frames with random stalls; a start pulse while busy must be ignored
    launch(8'd3, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1 start = 1; nframes = 8'd5; fwd_inv = 1'b1;
    @(posedge clk); #1 start = 0;
    finish_test("t2_three_frames");

    // config channel backpressure for 10 cycles
    cfg_tready = 0; hold_cnt = 0;
    launch(8'd1, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1 cfg_tready = 1;
    finish_test("t3_cfg_stall");
    chk("t3_cfg_hold_cycles", 64'(hold_cnt), 64'd10);

    // early result tlast on beat 10 of frame 0, missing tlast on frame 1
    inj_early = 0; inj_miss = 1;
    launch(8'd2, 1'b1, 1'b0);
    finish_test("t4_framing_err");

    // nframes=0 runs a single frame
    launch(8'd0, 1'b0, 1'b0);
    finish_test("t5_nframes0");

    // reset mid-LOAD after beat 7, then a clean frame
    launch(8'd1, 1'b1, 1'b0);
    c = 0;
    while (in_beats < 7 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t6_reached_beat7", 64'(in_beats), 64'd7);
    @(posedge clk); #1;
    sys_rst_n = 0; src_en = 0;
    @(posedge clk); #1;
    sys_rst_n = 1;
    exp_in.delete(); exp_cfg.delete(); exp_done.delete(); exp_err.delete();
    res_pending = 0;
    @(negedge clk);
    check_zero("t6_outputs_after_reset");
    launch(8'd1, 1'b1, 1'b0);
    finish_test("t6_clean_frame");

    finish_now();
  end

endmodule
`default_nettype wire
